tcp_buf_alloc_client: RTL and testbench



---
 rtl/tcp_buf_alloc_client.sv | 278 +++++++++++++++++++++++++++
 tb/tb_tcp_buf_alloc_client.sv | 555 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tcp_buf_alloc_client.sv
// -----------------------------------------------------------------------------
// tcp_buf_alloc_client
//
// Per-flow buffer manager on the initiator side of the TCP malloc/free
// interface. A flow open requests one LEN_MAX-sized buffer from the allocator
// and binds the returned address to the flow in a 2**FLOWID_W entry table.
// A flow close frees the bound buffer. All allocator traffic goes through a
// single FSM, so only one open or close is in flight at a time.
//
// Optional feature: define TCP_BUF_ALLOC_RETRY_EN to retry a failed malloc up
// to RETRY_MAX extra times before reporting failure. Without the macro the
// first failure is reported and no retry counter is built.
//
// Ports
//   clk, rst                       clock, synchronous active-high reset
//   open_req_*   (val/rdy/flowid)  open request from the flow-state engine
//   open_resp_*  (val/rdy/flowid/success/addr)  open result
//   close_req_*  (val/rdy/flowid)  close request
//   lookup_flowid -> lookup_hit/lookup_addr     registered table read
//   malloc_req_* / malloc_resp_*   allocator request/response channels
//   free_req_*                     allocator free channel
//   alloc_cnt                      number of valid table entries
//
// States
//   state        | meaning
//   S_IDLE       | ready to accept one open or close (close has priority)
//   S_ALLOC_REQ  | malloc_req_val asserted, waiting for malloc_req_rdy
//   S_ALLOC_WAIT | malloc_resp_rdy asserted, waiting for allocator result
//   S_OPEN_RESP  | open_resp_val asserted, waiting for open_resp_rdy
//   S_FREE_REQ   | free_req_val asserted, waiting for free_req_rdy
// -----------------------------------------------------------------------------
module tcp_buf_alloc_client #(
  parameter int PTR_W     = 16,
  parameter int LEN_MAX   = 2048,
  parameter int LEN_W     = $clog2(LEN_MAX),
  parameter int FLOWID_W  = 6,
  parameter int RETRY_MAX = 3
) (
  input  logic                clk,
  input  logic                rst,

  input  logic                open_req_val,
  output logic                open_req_rdy,
  input  logic [FLOWID_W-1:0] open_req_flowid,

  output logic                open_resp_val,
  input  logic                open_resp_rdy,
  output logic [FLOWID_W-1:0] open_resp_flowid,
  output logic                open_resp_success,
  output logic [PTR_W-1:0]    open_resp_addr,

  input  logic                close_req_val,
  output logic                close_req_rdy,
  input  logic [FLOWID_W-1:0] close_req_flowid,

  input  logic [FLOWID_W-1:0] lookup_flowid,
  output logic                lookup_hit,
  output logic [PTR_W-1:0]    lookup_addr,

  output logic                malloc_req_val,
  input  logic                malloc_req_rdy,
  output logic [LEN_W-1:0]    malloc_req_len,

  input  logic                malloc_resp_val,
  output logic                malloc_resp_rdy,
  input  logic                malloc_resp_success,
  input  logic [PTR_W-1:0]    malloc_resp_addr,

  output logic                free_req_val,
  input  logic                free_req_rdy,
  output logic [PTR_W-1:0]    free_req_addr,
  output logic [LEN_W-1:0]    free_req_len,

  output logic [FLOWID_W:0]   alloc_cnt
);

  localparam int NUM_FLOWS = 2**FLOWID_W;
  localparam int CNT_W     = FLOWID_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(NUM_FLOWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ALLOC_REQ,
    S_ALLOC_WAIT,
    S_OPEN_RESP,
    S_FREE_REQ
  } state_t;

  state_t state_q, state_d;

  // Flow table: valid bits are reset, address storage is not.
  logic [NUM_FLOWS-1:0] valid_q;
  logic [PTR_W-1:0]     addr_mem [NUM_FLOWS];

  logic [FLOWID_W-1:0]  flowid_q;
  logic [PTR_W-1:0]     free_addr_q;
  logic [CNT_W-1:0]     cnt_q;

  logic open_hit;
  logic close_hit;
  logic open_acc;
  logic close_acc;
  logic alloc_ok;
  logic alloc_fail;

  assign open_hit  = valid_q[open_req_flowid];
  assign close_hit = valid_q[close_req_flowid];

`ifdef TCP_BUF_ALLOC_RETRY_EN
  localparam int RETRY_W = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  logic [RETRY_W-1:0] retry_cnt_q;
  logic               retry_step;
  logic               retry_left;

  assign retry_left = (retry_cnt_q < RETRY_W'(RETRY_MAX));
`endif

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    open_acc   = 1'b0;
    close_acc  = 1'b0;
    alloc_ok   = 1'b0;
    alloc_fail = 1'b0;
`ifdef TCP_BUF_ALLOC_RETRY_EN
    retry_step = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        // Close is served first; the open stays pending until the next IDLE.
        if (close_req_val) begin
          close_acc = 1'b1;
          if (close_hit) begin
            state_d = S_FREE_REQ;
          end
        end else if (open_req_val) begin
          open_acc = 1'b1;
          state_d  = open_hit ? S_OPEN_RESP : S_ALLOC_REQ;
        end
      end
      S_ALLOC_REQ: begin
        if (malloc_req_rdy) begin
          state_d = S_ALLOC_WAIT;
        end
      end
      S_ALLOC_WAIT: begin
        if (malloc_resp_val) begin
          if (malloc_resp_success) begin
            alloc_ok = 1'b1;
            state_d  = S_OPEN_RESP;
          end else begin
`ifdef TCP_BUF_ALLOC_RETRY_EN
            if (retry_left) begin
              retry_step = 1'b1;
              state_d    = S_ALLOC_REQ;
            end else begin
              alloc_fail = 1'b1;
              state_d    = S_OPEN_RESP;
            end
`else
            alloc_fail = 1'b1;
            state_d    = S_OPEN_RESP;
`endif
          end
        end
      end
      S_OPEN_RESP: begin
        if (open_resp_rdy) begin
          state_d = S_IDLE;
        end
      end
      S_FREE_REQ: begin
        if (free_req_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Handshake outputs are decoded from state only. open_req_rdy also drops
  // while a close is offered so a val&rdy pair always means acceptance.
  assign open_req_rdy    = (state_q == S_IDLE) && !rst && !close_req_val;
  assign close_req_rdy   = (state_q == S_IDLE) && !rst;
  assign malloc_req_val  = (state_q == S_ALLOC_REQ);
  assign malloc_resp_rdy = (state_q == S_ALLOC_WAIT);
  assign open_resp_val   = (state_q == S_OPEN_RESP);
  assign free_req_val    = (state_q == S_FREE_REQ);

  // Length is truncated to the allocator's field width; with a power-of-two
  // LEN_MAX this wraps, which the allocator must interpret consistently.
  assign malloc_req_len  = LEN_W'(LEN_MAX);
  assign free_req_len    = LEN_W'(LEN_MAX);
  assign free_req_addr   = free_addr_q;
  assign alloc_cnt       = cnt_q;

  // ---------------------------------------------------------------------------
  // Table, counters and response registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q           <= '0;
      cnt_q             <= '0;
      flowid_q          <= '0;
      free_addr_q       <= '0;
      lookup_hit        <= 1'b0;
      lookup_addr       <= '0;
      open_resp_flowid  <= '0;
      open_resp_success <= 1'b0;
      open_resp_addr    <= '0;
    end else begin
      // Registered read sees the table before any write on this edge.
      lookup_hit  <= valid_q[lookup_flowid];
      lookup_addr <= addr_mem[lookup_flowid];

      if (open_acc) begin
        flowid_q          <= open_req_flowid;
        open_resp_flowid  <= open_req_flowid;
        open_resp_success <= 1'b0;
        open_resp_addr    <= '0;
      end

      if (alloc_ok) begin
        valid_q[flowid_q] <= 1'b1;
        open_resp_success <= 1'b1;
        open_resp_addr    <= malloc_resp_addr;
        if (cnt_q != CNT_FULL) begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      if (alloc_fail) begin
        open_resp_success <= 1'b0;
        open_resp_addr    <= '0;
      end

      if (close_acc && close_hit) begin
        valid_q[close_req_flowid] <= 1'b0;
        free_addr_q               <= addr_mem[close_req_flowid];
        if (cnt_q != '0) begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && alloc_ok) begin
      addr_mem[flowid_q] <= malloc_resp_addr;
    end
  end

`ifdef TCP_BUF_ALLOC_RETRY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retry_cnt_q <= '0;
    end else if (open_acc) begin
      retry_cnt_q <= '0;
    end else if (retry_step) begin
      retry_cnt_q <= retry_cnt_q + RETRY_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_tcp_buf_alloc_client.sv
// -----------------------------------------------------------------------------
// tb_tcp_buf_alloc_client
//
// Bench for tcp_buf_alloc_client. A bench-side allocator answers malloc and
// free traffic; a bus monitor records handshakes; a flow-table model (arrays
// of valid/addr plus an entry count) predicts every response. Inputs change
// 1 time unit after the rising edge, the monitor samples on the falling edge.
// -----------------------------------------------------------------------------
module tb_tcp_buf_alloc_client;

  localparam int PTR_W     = 16;
  localparam int LEN_MAX   = 2048;
  localparam int LEN_W     = $clog2(LEN_MAX);
  localparam int FLOWID_W  = 6;
  localparam int RETRY_MAX = 3;
  localparam int NF        = 2**FLOWID_W;
  localparam int CNT_W     = FLOWID_W + 1;
  localparam int TMO       = 300;
`ifdef TCP_BUF_ALLOC_RETRY_EN
  localparam int MAX_ATT   = RETRY_MAX + 1;
`else
  localparam int MAX_ATT   = 1;
`endif

  logic                clk;
  logic                rst;
  logic                open_req_val;
  logic                open_req_rdy;
  logic [FLOWID_W-1:0] open_req_flowid;
  logic                open_resp_val;
  logic                open_resp_rdy;
  logic [FLOWID_W-1:0] open_resp_flowid;
  logic                open_resp_success;
  logic [PTR_W-1:0]    open_resp_addr;
  logic                close_req_val;
  logic                close_req_rdy;
  logic [FLOWID_W-1:0] close_req_flowid;
  logic [FLOWID_W-1:0] lookup_flowid;
  logic                lookup_hit;
  logic [PTR_W-1:0]    lookup_addr;
  logic                malloc_req_val;
  logic                malloc_req_rdy;
  logic [LEN_W-1:0]    malloc_req_len;
  logic                malloc_resp_val;
  logic                malloc_resp_rdy;
  logic                malloc_resp_success;
  logic [PTR_W-1:0]    malloc_resp_addr;
  logic                free_req_val;
  logic                free_req_rdy;
  logic [PTR_W-1:0]    free_req_addr;
  logic [LEN_W-1:0]    free_req_len;
  logic [FLOWID_W:0]   alloc_cnt;

  tcp_buf_alloc_client #(
    .PTR_W(PTR_W), .LEN_MAX(LEN_MAX), .LEN_W(LEN_W),
    .FLOWID_W(FLOWID_W), .RETRY_MAX(RETRY_MAX)
  ) dut (
    .clk(clk), .rst(rst),
    .open_req_val(open_req_val), .open_req_rdy(open_req_rdy),
    .open_req_flowid(open_req_flowid),
    .open_resp_val(open_resp_val), .open_resp_rdy(open_resp_rdy),
    .open_resp_flowid(open_resp_flowid), .open_resp_success(open_resp_success),
    .open_resp_addr(open_resp_addr),
    .close_req_val(close_req_val), .close_req_rdy(close_req_rdy),
    .close_req_flowid(close_req_flowid),
    .lookup_flowid(lookup_flowid), .lookup_hit(lookup_hit), .lookup_addr(lookup_addr),
    .malloc_req_val(malloc_req_val), .malloc_req_rdy(malloc_req_rdy),
    .malloc_req_len(malloc_req_len),
    .malloc_resp_val(malloc_resp_val), .malloc_resp_rdy(malloc_resp_rdy),
    .malloc_resp_success(malloc_resp_success), .malloc_resp_addr(malloc_resp_addr),
    .free_req_val(free_req_val), .free_req_rdy(free_req_rdy),
    .free_req_addr(free_req_addr), .free_req_len(free_req_len),
    .alloc_cnt(alloc_cnt)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Flow table model
  bit               m_valid [NF];
  logic [PTR_W-1:0] m_addr  [NF];
  int               m_cnt;
  logic [LEN_W-1:0] exp_len;

  // Allocator behaviour knobs
  bit               rnd_mode   = 0;
  bit               rnd_fail   = 0;
  bit               fail_all   = 0;
  int               mreq_stall = 0;
  int               free_stall = 0;
  logic [PTR_W-1:0] grant_addr = '0;

  // Monitor results
  int  cyc = 0;
  int  n_malloc = 0, n_free = 0, n_open_acc = 0, n_close_acc = 0, n_oresp = 0;
  int  open_acc_cyc = 0, close_acc_cyc = 0, oresp_cyc = 0, free_cyc = 0;
  bit  mreq_fire = 0, mresp_fire = 0;
  bit               g_ok_q   [$];
  logic [PTR_W-1:0] g_addr_q [$];
  logic [PTR_W-1:0] free_addr_q [$];
  logic [LEN_W-1:0] free_len_q  [$];
  logic [FLOWID_W-1:0] or_flow_q [$];
  bit                  or_ok_q   [$];
  logic [PTR_W-1:0]    or_addr_q [$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  // Bus monitor: values seen at the falling edge are what the next rising
  // edge samples, since nothing changes in between.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      mreq_fire  = malloc_req_val && malloc_req_rdy;
      mresp_fire = malloc_resp_val && malloc_resp_rdy;
      if (mreq_fire) n_malloc++;
      if (mresp_fire) begin
        g_ok_q.push_back(malloc_resp_success);
        g_addr_q.push_back(malloc_resp_addr);
      end
      if (free_req_val && free_req_rdy) begin
        n_free++;
        free_cyc = cyc;
        free_addr_q.push_back(free_req_addr);
        free_len_q.push_back(free_req_len);
      end
      if (open_req_val && open_req_rdy) begin
        n_open_acc++;
        open_acc_cyc = cyc;
      end
      if (close_req_val && close_req_rdy) begin
        n_close_acc++;
        close_acc_cyc = cyc;
      end
      if (open_resp_val && open_resp_rdy) begin
        n_oresp++;
        oresp_cyc = cyc;
        or_flow_q.push_back(open_resp_flowid);
        or_ok_q.push_back(open_resp_success);
        or_addr_q.push_back(open_resp_addr);
      end
    end
  end

  // Allocator and response-side ready driver
  initial begin
    bit pending;
    int resp_wait;
    pending = 0;
    resp_wait = 0;
    malloc_req_rdy = 1'b0;
    malloc_resp_val = 1'b0;
    malloc_resp_success = 1'b0;
    malloc_resp_addr = '0;
    free_req_rdy = 1'b0;
    open_resp_rdy = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        malloc_resp_val = 1'b0;
        pending = 0;
      end else begin
        if (mresp_fire) malloc_resp_val = 1'b0;
        if (mreq_fire) begin
          pending = 1;
          resp_wait = rnd_mode ? $urandom_range(0, 2) : 0;
        end
        if (pending && !malloc_resp_val) begin
          if (resp_wait == 0) begin
            malloc_resp_val = 1'b1;
            malloc_resp_success = fail_all ? 1'b0 :
                                  (rnd_fail ? ($urandom_range(0, 3) != 0) : 1'b1);
            malloc_resp_addr = rnd_mode ? PTR_W'($urandom) : grant_addr;
            pending = 0;
          end else begin
            resp_wait--;
          end
        end
      end
      if (mreq_stall > 0) begin
        malloc_req_rdy = 1'b0;
        mreq_stall--;
      end else begin
        malloc_req_rdy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (free_stall > 0) begin
        free_req_rdy = 1'b0;
        free_stall--;
      end else begin
        free_req_rdy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      open_resp_rdy = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Open a flow; predicted result comes from the table model and the
  // sequence of allocator answers seen on the bus.
  task automatic open_flow(input logic [FLOWID_W-1:0] f, input logic [PTR_W-1:0] a,
                           output int lat);
    int acc0, r0, m0, t, first_ok, exp_att;
    bit was_valid, exp_ok;
    logic [PTR_W-1:0] exp_addr;
    logic [FLOWID_W-1:0] got_flow;
    bit got_ok;
    logic [PTR_W-1:0] got_addr;
    lat = -1;
    was_valid = m_valid[f];
    acc0 = n_open_acc;
    r0 = n_oresp;
    m0 = n_malloc;
    g_ok_q.delete();
    g_addr_q.delete();
    grant_addr = a;
    open_req_flowid = f;
    open_req_val = 1'b1;
    t = 0;
    while (n_open_acc == acc0 && t < TMO) begin tick(); t++; end
    open_req_val = 1'b0;
    n_checks++;
    if (n_open_acc == acc0) begin
      n_fail++;
      $display("FAIL open_accept flow %0d: got no accept expected accept within %0d cycles", f, TMO);
      return;
    end
    t = 0;
    while (n_oresp == r0 && t < TMO) begin tick(); t++; end
    n_checks++;
    if (n_oresp == r0) begin
      n_fail++;
      $display("FAIL open_resp_timeout flow %0d: got no response expected one within %0d cycles", f, TMO);
      return;
    end
    lat = oresp_cyc - open_acc_cyc;
    got_flow = or_flow_q.pop_front();
    got_ok = or_ok_q.pop_front();
    got_addr = or_addr_q.pop_front();

    if (was_valid) begin
      exp_ok = 0; exp_addr = '0; exp_att = 0;
    end else begin
      first_ok = -1;
      foreach (g_ok_q[i]) if (g_ok_q[i] && first_ok < 0) first_ok = i;
      if (first_ok >= 0) begin
        exp_ok = 1; exp_addr = g_addr_q[first_ok]; exp_att = first_ok + 1;
      end else begin
        exp_ok = 0; exp_addr = '0; exp_att = MAX_ATT;
      end
    end

    n_checks++;
    if (got_flow !== f) begin
      n_fail++;
      $display("FAIL open_resp_flowid: got %0d expected %0d", got_flow, f);
    end
    n_checks++;
    if (got_ok !== exp_ok) begin
      n_fail++;
      $display("FAIL open_resp_success flow %0d: got %0d expected %0d", f, got_ok, exp_ok);
    end
    n_checks++;
    if (got_addr !== exp_addr) begin
      n_fail++;
      $display("FAIL open_resp_addr flow %0d: got %h expected %h", f, got_addr, exp_addr);
    end
    n_checks++;
    if ((n_malloc - m0) != exp_att) begin
      n_fail++;
      $display("FAIL malloc_attempts flow %0d: got %0d expected %0d", f, n_malloc - m0, exp_att);
    end
    if (exp_ok) begin
      m_valid[f] = 1;
      m_addr[f] = exp_addr;
      m_cnt++;
    end
  endtask

  task automatic close_flow(input logic [FLOWID_W-1:0] f, output int lat);
    int c0, f0, t;
    bit was_valid;
    logic [PTR_W-1:0] got_addr;
    logic [LEN_W-1:0] got_len;
    lat = -1;
    was_valid = m_valid[f];
    c0 = n_close_acc;
    f0 = n_free;
    close_req_flowid = f;
    close_req_val = 1'b1;
    t = 0;
    while (n_close_acc == c0 && t < TMO) begin tick(); t++; end
    close_req_val = 1'b0;
    n_checks++;
    if (n_close_acc == c0) begin
      n_fail++;
      $display("FAIL close_accept flow %0d: got no accept expected accept within %0d cycles", f, TMO);
      return;
    end
    if (was_valid) begin
      t = 0;
      while (n_free == f0 && t < TMO) begin tick(); t++; end
      n_checks++;
      if (n_free == f0) begin
        n_fail++;
        $display("FAIL free_timeout flow %0d: got no free expected one within %0d cycles", f, TMO);
        return;
      end
      lat = free_cyc - close_acc_cyc;
      got_addr = free_addr_q.pop_front();
      got_len = free_len_q.pop_front();
      n_checks++;
      if (got_addr !== m_addr[f]) begin
        n_fail++;
        $display("FAIL free_addr flow %0d: got %h expected %h", f, got_addr, m_addr[f]);
      end
      n_checks++;
      if (got_len !== exp_len) begin
        n_fail++;
        $display("FAIL free_len flow %0d: got %0d expected %0d", f, got_len, exp_len);
      end
      m_valid[f] = 0;
      m_cnt--;
    end else begin
      repeat (6) tick();
      lat = 0;
      n_checks++;
      if (n_free != f0) begin
        n_fail++;
        $display("FAIL spurious_free flow %0d: got %0d frees expected 0", f, n_free - f0);
      end
    end
  endtask

  task automatic check_lookup(input logic [FLOWID_W-1:0] f);
    lookup_flowid = f;
    tick();
    n_checks++;
    if (lookup_hit !== m_valid[f]) begin
      n_fail++;
      $display("FAIL lookup_hit flow %0d: got %0d expected %0d", f, lookup_hit, m_valid[f]);
    end
    if (m_valid[f]) begin
      n_checks++;
      if (lookup_addr !== m_addr[f]) begin
        n_fail++;
        $display("FAIL lookup_addr flow %0d: got %h expected %h", f, lookup_addr, m_addr[f]);
      end
    end
    n_checks++;
    if (alloc_cnt !== CNT_W'(m_cnt)) begin
      n_fail++;
      $display("FAIL alloc_cnt: got %0d expected %0d", alloc_cnt, m_cnt);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    open_req_val = 1'b0; open_req_flowid = '0;
    close_req_val = 1'b0; close_req_flowid = '0;
    lookup_flowid = '0;
    repeat (3) tick();
    n_checks++;
    if ({open_resp_val, malloc_req_val, free_req_val, malloc_resp_rdy} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_vals: got %b expected 0000",
               {open_resp_val, malloc_req_val, free_req_val, malloc_resp_rdy});
    end
    n_checks++;
    if (lookup_hit !== 1'b0 || alloc_cnt !== '0 || open_resp_addr !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got hit=%0d cnt=%0d addr=%h expected 0 0 0",
               lookup_hit, alloc_cnt, open_resp_addr);
    end
    n_checks++;
    if (open_req_rdy !== 1'b0 || close_req_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rdy: got open=%0d close=%0d expected 0 0", open_req_rdy, close_req_rdy);
    end
    rst = 1'b0;
    tick();
    n_checks++;
    if (open_req_rdy !== 1'b1 || close_req_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL idle_rdy: got open=%0d close=%0d expected 1 1", open_req_rdy, close_req_rdy);
    end
    for (int i = 0; i < NF; i++) m_valid[i] = 0;
    m_cnt = 0;
  endtask

  task automatic test_open_basic();
    int lat;
    n_checks++;
    if (malloc_req_len !== exp_len) begin
      n_fail++;
      $display("FAIL malloc_req_len: got %0d expected %0d", malloc_req_len, exp_len);
    end
    open_flow(6'd5, 16'h0800, lat);
    n_checks++;
    if (m_addr[5] !== 16'h0800 || !m_valid[5]) begin
      n_fail++;
      $display("FAIL open_basic_bind: got valid=%0d addr=%h expected 1 0800", m_valid[5], m_addr[5]);
    end
    n_checks++;
    if (lat != 3) begin
      n_fail++;
      $display("FAIL open_latency: got %0d expected 3", lat);
    end
    check_lookup(6'd5);
  endtask

  task automatic test_close_basic();
    int lat;
    close_flow(6'd5, lat);
    n_checks++;
    if (lat != 1) begin
      n_fail++;
      $display("FAIL close_latency: got %0d expected 1", lat);
    end
    check_lookup(6'd5);
  endtask

  task automatic test_close_unopened();
    int lat;
    close_flow(6'd9, lat);
    check_lookup(6'd9);
  endtask

  task automatic test_double_open();
    int lat;
    open_flow(6'd5, 16'h0800, lat);
    open_flow(6'd5, 16'h0900, lat);
    check_lookup(6'd5);
    close_flow(6'd5, lat);
    check_lookup(6'd5);
  endtask

  task automatic test_alloc_fail();
    int lat, m0;
    m0 = n_malloc;
    fail_all = 1;
    open_flow(6'd12, 16'h0abc, lat);
    fail_all = 0;
    n_checks++;
    if ((n_malloc - m0) != MAX_ATT) begin
      n_fail++;
      $display("FAIL fail_malloc_count: got %0d expected %0d", n_malloc - m0, MAX_ATT);
    end
    check_lookup(6'd12);
  endtask

  task automatic test_back_to_back();
    int lat, c0, o0, f0, r0, t, stall_cycles;
    bit stall_ok;
    open_flow(6'd20, 16'h1234, lat);
    c0 = n_close_acc; o0 = n_open_acc; f0 = n_free; r0 = n_oresp;
    grant_addr = 16'h2222;
    stall_cycles = 0;
    stall_ok = 1;
    close_req_flowid = 6'd20; close_req_val = 1'b1;
    open_req_flowid = 6'd21;  open_req_val = 1'b1;
    mreq_stall = 5; free_stall = 5;
    t = 0;
    while (n_oresp == r0 && t < TMO) begin
      tick();
      t++;
      if (n_close_acc != c0) close_req_val = 1'b0;
      if (n_open_acc != o0) open_req_val = 1'b0;
      if (n_close_acc != c0 && n_free == f0) begin
        stall_cycles++;
        if (free_req_val !== 1'b1 || free_req_addr !== 16'h1234 || n_open_acc != o0)
          stall_ok = 0;
      end
    end
    open_req_val = 1'b0;
    close_req_val = 1'b0;
    n_checks++;
    if (n_oresp == r0 || n_close_acc == c0 || n_free == f0) begin
      n_fail++;
      $display("FAIL b2b_timeout: got close=%0d free=%0d resp=%0d expected 1 1 1",
               n_close_acc - c0, n_free - f0, n_oresp - r0);
      return;
    end
    n_checks++;
    if (!stall_ok || stall_cycles < 4) begin
      n_fail++;
      $display("FAIL b2b_free_stall: got stable=%0d cycles=%0d expected 1 and >=4", stall_ok, stall_cycles);
    end
    n_checks++;
    if (!(close_acc_cyc < open_acc_cyc)) begin
      n_fail++;
      $display("FAIL b2b_order: got close@%0d open@%0d expected close first", close_acc_cyc, open_acc_cyc);
    end
    n_checks++;
    if ((n_free - f0) != 1 || free_addr_q[0] !== 16'h1234) begin
      n_fail++;
      $display("FAIL b2b_free: got n=%0d addr=%h expected 1 1234", n_free - f0, free_addr_q[0]);
    end
    n_checks++;
    if (or_flow_q[0] !== 6'd21 || or_ok_q[0] !== 1'b1 || or_addr_q[0] !== 16'h2222) begin
      n_fail++;
      $display("FAIL b2b_open_resp: got flow=%0d ok=%0d addr=%h expected 21 1 2222",
               or_flow_q[0], or_ok_q[0], or_addr_q[0]);
    end
    free_addr_q.delete(); free_len_q.delete();
    or_flow_q.delete(); or_ok_q.delete(); or_addr_q.delete();
    m_valid[20] = 0; m_cnt--;
    m_valid[21] = 1; m_addr[21] = 16'h2222; m_cnt++;
    check_lookup(6'd20);
    check_lookup(6'd21);
  endtask

  task automatic test_random();
    int lat;
    logic [FLOWID_W-1:0] f;
    rnd_mode = 1;
    rnd_fail = 1;
    for (int i = 0; i < 40; i++) begin
      f = FLOWID_W'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1) open_flow(f, '0, lat);
      else close_flow(f, lat);
      check_lookup(FLOWID_W'($urandom_range(0, 7)));
    end
    rnd_mode = 0;
    rnd_fail = 0;
  endtask

  initial begin
    exp_len = LEN_W'(LEN_MAX);
    m_cnt = 0;
    test_reset();
    test_open_basic();
    test_close_basic();
    test_close_unopened();
    test_double_open();
    test_alloc_fail();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
